data_port_ctrl: RTL and testbench
=================================

Name: data_port_ctrl

Overview:
- Initiator for the unified RAM's data port, sitting between the core's load/store pipeline stage and the RAM.
- Accepts byte, halfword and word loads/stores over a valid/ready request interface.
- Drives word-aligned RAM accesses and performs read-modify-write for sub-word stores.
- Returns sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
- ADDR_WIDTH, 16, byte-address width; must match the RAM's ADDR_WIDTH.
- DATA_WIDTH, 32, word width; only 32 is supported, and elaboration fails otherwise.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned or illegal-size request; qualified by resp_valid.
- mem_wEn  out  1  RAM write enable.
- mem_address  out  ADDR_WIDTH  RAM byte address; bits [1:0] always 0.
- mem_write_data  out  32  RAM write word.
- mem_read_data  in  32  RAM combinational read word.

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to IDLE.
  - resp_valid=0, resp_error=0, resp_rdata=0; latched address and data regs are 0.
  - mem_wEn is gated by reset, so no RAM write occurs at the reset edge, even from WRITE.
- States: IDLE, WRITE, RESP.
- IDLE:
  - req_ready=1, mem_wEn=0.
  - mem_address = {req_addr[ADDR_WIDTH-1:2],2'b00}, combinational pass-through so that mem_read_data is valid in the same cycle.
  - Accept on posedge when req_valid=1. Latch the word address, byte offset req_addr[1:0], size, unsigned flag and we.
- Error check (at acceptance):
  - Error when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - On error: go to RESP with resp_error=1, resp_rdata=0, and no RAM write.
- Load (at acceptance):
  - Extract the lane from mem_read_data: byte = word[8*off+7:8*off]; half = word[16*off[1]+15:16*off[1]].
  - Sign- or zero-extend per req_unsigned; word loads pass through.
  - Register the result into resp_rdata and go to RESP.
  - Latency: accept at edge N, resp_valid high during cycle N+1.
- Store (at acceptance):
  - Merge req_wdata into the captured mem_read_data. Byte replaces lane off; half replaces lanes {off[1],0} and {off[1],1}; word replaces all.
  - Register the merged word into mem_write_data and go to WRITE.
- WRITE:
  - mem_wEn=1 for exactly one cycle, with mem_address = latched word address and mem_write_data = merged word.
  - Then go to RESP.
  - Store latency: mem_wEn in cycle N+1, resp_valid in cycle N+2.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - No response backpressure; the core must sample in that cycle.
- Throughput:
  - Next request is accepted in the cycle after RESP, i.e. one load per 2 cycles and one store per 3 cycles.
  - req_valid held during non-IDLE states is ignored and not lost; the core keeps it asserted until req_ready.
- Hazard: the RMW read and write are non-atomic against other writers. This is acceptable because this controller is the RAM's only data-port writer.
- Address wrap: the top word (all-ones address) is legal; there is no wrap logic.
- Outputs outside their states:
  - mem_write_data holds its last value outside WRITE.
  - resp_rdata and resp_error hold their value outside RESP; consumers qualify them with resp_valid.

Decomposition:
- Shared package dmem_pkg holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the state encoding IDLE/WRITE/RESP;
  - the function is_misaligned(size, off).
- One sub-module, load_extract: combinational (word, off, size, unsigned) -> 32-bit extended data. It is reused by the core's debug readback.
- Store merge stays inline.

Test Plan:
- RAM[0x0010]=0x8899AABB; load byte, signed, addr 0x0011 -> resp_valid at N+1, resp_rdata=0xFFFFFFAA, resp_error=0; unsigned -> 0x000000AA.
- Same word; load half, signed, addr 0x0012 -> 0xFFFF8899. Word load at 0x0010 -> 0x8899AABB.
- RAM[0x0020]=0x11223344; store byte 0xEE at 0x0023 -> mem_wEn only in N+1, mem_write_data=0xEE223344, resp_valid N+2; RAM word is 0xEE223344.
- Half load at 0x0011 and word store at 0x0022 -> resp_error=1, resp_rdata=0, mem_wEn never asserted, RAM unchanged; size=11 also errors.
- Store issued, reset=0 during the WRITE cycle -> no RAM change, state IDLE, req_ready=1, resp_valid=0 next cycle.
- Back-to-back: req_valid held continuously for load, store, load -> req_ready low except in IDLE, all three complete in order, the second load observes the stored data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-port controller: size codes, FSM state
// encoding and the alignment rule used at request acceptance.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Size code 2'b11 is illegal and therefore always reported as an error.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         SZ_WORD: return off != 2'b00;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/data_port_ctrl_if.sv
// Core-side request/response channel of the data-port controller.
// The core is the master; the controller is the slave.
interface data_port_ctrl_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;
   logic                  resp_valid;
   logic [31:0]           resp_rdata;
   logic                  resp_error;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/data_port_ctrl_load_extract.sv
// Combinational lane select and sign/zero extension of a RAM word.
// Shared with the core's debug readback path.
module load_extract
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      byte_lane = word[7:0];
      data      = word;
      case (off)
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         2'd3:    byte_lane = word[31:24];
         default: byte_lane = word[7:0];
      endcase
      half_lane = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
         SZ_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
         default: data = word;
      endcase
   end
endmodule

// File: rtl/data_port_ctrl.sv
// Data-port initiator for the unified RAM: word-aligned accesses, read-modify-write
// for sub-word stores, extended load data with a one-cycle response pulse.
module data_port_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   data_port_ctrl_if.slave       port,
   output logic                  mem_wEn,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   input  logic [31:0]           mem_read_data
);
   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("data_port_ctrl supports DATA_WIDTH=32 only");
   end

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-3:0] word_addr_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_q;
   logic                  error_q;

   logic [1:0]            off;
   logic                  accept;
   logic                  req_err;
   logic [31:0]           load_data;
   logic [31:0]           merged;

   assign off     = port.req_addr[1:0];
   assign accept  = (state_q == IDLE) && port.req_valid;
   assign req_err = is_misaligned(port.req_size, off);

   load_extract u_load_extract (
      .word        (mem_read_data),
      .off         (off),
      .size        (port.req_size),
      .is_unsigned (port.req_unsigned),
      .data        (load_data)
   );

   // Store merge into the word read in the acceptance cycle.
   always_comb begin
      merged = mem_read_data;
      case (port.req_size)
         SZ_BYTE: begin
            case (off)
               2'd0:    merged[7:0]   = port.req_wdata[7:0];
               2'd1:    merged[15:8]  = port.req_wdata[7:0];
               2'd2:    merged[23:16] = port.req_wdata[7:0];
               default: merged[31:24] = port.req_wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off[1]) merged[31:16] = port.req_wdata[15:0];
            else        merged[15:0]  = port.req_wdata[15:0];
         end
         default: merged = port.req_wdata;
      endcase
   end

   always_comb begin
      state_d         = state_q;
      port.req_ready  = 1'b0;
      port.resp_valid = 1'b0;
      mem_wEn         = 1'b0;
      mem_address     = {word_addr_q, 2'b00};
      case (state_q)
         IDLE: begin
            port.req_ready = 1'b1;
            // Pass-through so the RAM's combinational read lands in this cycle.
            mem_address    = {port.req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (port.req_valid)
               state_d = (req_err || !port.req_we) ? RESP : WRITE;
         end
         WRITE: begin
            // Reset gates the strobe so an interrupted store never reaches the RAM.
            mem_wEn = reset;
            state_d = RESP;
         end
         RESP: begin
            port.resp_valid = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         word_addr_q <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            word_addr_q <= port.req_addr[ADDR_WIDTH-1:2];
            if (req_err) begin
               error_q <= 1'b1;
               rdata_q <= '0;
            end else if (port.req_we) begin
               error_q <= 1'b0;
               rdata_q <= '0;
               wdata_q <= merged;
            end else begin
               error_q <= 1'b0;
               rdata_q <= load_data;
            end
         end
      end
   end

   assign port.resp_rdata = rdata_q;
   assign port.resp_error = error_q;
   assign mem_write_data  = wdata_q;
endmodule

// File: tb/tb_data_port_ctrl.sv
// Directed bench for data_port_ctrl with a behavioural word RAM.
module tb_data_port_ctrl;
   import dmem_pkg::*;

   localparam int AW = 16;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          mem_wEn;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_write_data;
   logic [31:0]   mem_read_data;

   logic [31:0]   ram [0:(1<<(AW-2))-1];
   int            wen_count = 0;
   int            checks    = 0;
   int            failures  = 0;

   data_port_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

   data_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .port           (bus),
      .mem_wEn        (mem_wEn),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clock = ~clock;

   assign mem_read_data = ram[mem_address[AW-1:2]];

   always @(posedge clock) begin
      if (mem_wEn) begin
         ram[mem_address[AW-1:2]] <= mem_write_data;
         wen_count <= wen_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Issue one request and follow it cycle by cycle to its response.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [31:0] exp_wdata);
      int wen_before;
      wen_before = wen_count;
      check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      step();
      bus.req_valid = 1'b0;
      if (we && !exp_err) begin
         check({tag, ".wen"},   32'(mem_wEn), 32'd1);
         check({tag, ".waddr"}, 32'(mem_address), 32'(addr & 16'hFFFC));
         check({tag, ".wdata"}, mem_write_data, exp_wdata);
         check({tag, ".early_resp"}, 32'(bus.resp_valid), 32'd0);
         step();
      end
      check({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, ".resp_error"}, 32'(bus.resp_error), 32'(exp_err));
      check({tag, ".resp_rdata"}, bus.resp_rdata, exp_rdata);
      check({tag, ".resp_ready"}, 32'(bus.req_ready), 32'd0);
      step();
      check({tag, ".resp_pulse"}, 32'(bus.resp_valid), 32'd0);
      check({tag, ".wen_count"},  32'(wen_count - wen_before), (we && !exp_err) ? 32'd1 : 32'd0);
   endtask

   initial begin
      for (int i = 0; i < (1 << (AW-2)); i++) ram[i] = 32'h0;
      ram[16'h0010 >> 2] = 32'h8899AABB;
      ram[16'h0020 >> 2] = 32'h11223344;
      ram[16'h0030 >> 2] = 32'h55667788;
      ram[16'h0040 >> 2] = 32'h01020304;
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = SZ_WORD;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;

      step();
      step();
      reset = 1'b1;
      check("rst.ready",      32'(bus.req_ready),  32'd1);
      check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst.resp_error", 32'(bus.resp_error), 32'd0);
      check("rst.resp_rdata", bus.resp_rdata,      32'd0);
      check("rst.wen",        32'(mem_wEn),        32'd0);
      check("rst.wdata",      mem_write_data,      32'd0);

      // Loads from 0x8899AABB
      do_req("lb_s_11",  1'b0, SZ_BYTE, 1'b0, 16'h0011, 32'h0, 32'hFFFFFFAA, 1'b0, 32'h0);
      do_req("lb_u_11",  1'b0, SZ_BYTE, 1'b1, 16'h0011, 32'h0, 32'h000000AA, 1'b0, 32'h0);
      do_req("lb_s_10",  1'b0, SZ_BYTE, 1'b0, 16'h0010, 32'h0, 32'hFFFFFFBB, 1'b0, 32'h0);
      do_req("lb_u_13",  1'b0, SZ_BYTE, 1'b1, 16'h0013, 32'h0, 32'h00000088, 1'b0, 32'h0);
      do_req("lh_s_12",  1'b0, SZ_HALF, 1'b0, 16'h0012, 32'h0, 32'hFFFF8899, 1'b0, 32'h0);
      do_req("lh_u_10",  1'b0, SZ_HALF, 1'b1, 16'h0010, 32'h0, 32'h0000AABB, 1'b0, 32'h0);
      do_req("lw_10",    1'b0, SZ_WORD, 1'b0, 16'h0010, 32'h0, 32'h8899AABB, 1'b0, 32'h0);
      do_req("lb_s_20",  1'b0, SZ_BYTE, 1'b0, 16'h0020, 32'h0, 32'h00000044, 1'b0, 32'h0);

      // Stores with read-modify-write
      do_req("sb_23", 1'b1, SZ_BYTE, 1'b0, 16'h0023, 32'h000000EE, 32'h0, 1'b0, 32'hEE223344);
      check("sb_23.ram", ram[16'h0020 >> 2], 32'hEE223344);
      do_req("sh_20", 1'b1, SZ_HALF, 1'b0, 16'h0020, 32'h12345A5A, 32'h0, 1'b0, 32'hEE225A5A);
      check("sh_20.ram", ram[16'h0020 >> 2], 32'hEE225A5A);

      // Errors: no RAM write, rdata forced to zero
      do_req("err_lh_11", 1'b0, SZ_HALF, 1'b0, 16'h0011, 32'h0,        32'h0, 1'b1, 32'h0);
      do_req("err_sw_22", 1'b1, SZ_WORD, 1'b0, 16'h0022, 32'hDEADBEEF, 32'h0, 1'b1, 32'h0);
      check("err_sw_22.ram", ram[16'h0020 >> 2], 32'hEE225A5A);
      do_req("err_sz11",  1'b0, 2'b11,   1'b0, 16'h0010, 32'h0,        32'h0, 1'b1, 32'h0);
      do_req("err_sb_sz11", 1'b1, 2'b11, 1'b0, 16'h0020, 32'h0,        32'h0, 1'b1, 32'h0);
      check("err_sz11.ram", ram[16'h0020 >> 2], 32'hEE225A5A);

      // Top word of the address space
      do_req("sw_top", 1'b1, SZ_WORD, 1'b0, 16'hFFFC, 32'hCAFEF00D, 32'h0, 1'b0, 32'hCAFEF00D);
      do_req("lb_top", 1'b0, SZ_BYTE, 1'b1, 16'hFFFF, 32'h0, 32'h000000CA, 1'b0, 32'h0);

      // Reset asserted during the WRITE cycle
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = SZ_WORD;
      bus.req_addr  = 16'h0030;
      bus.req_wdata = 32'hA5A5A5A5;
      step();
      bus.req_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("rstw.wen_gated", 32'(mem_wEn), 32'd0);
      step();
      reset = 1'b1;
      check("rstw.ram",        ram[16'h0030 >> 2],  32'h55667788);
      check("rstw.ready",      32'(bus.req_ready),  32'd1);
      check("rstw.resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rstw.wdata",      mem_write_data,      32'd0);

      // Back-to-back: load, store, load with req_valid held high
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = SZ_WORD;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 16'h0040;
      check("b2b.c0_ready", 32'(bus.req_ready), 32'd1);
      step();
      check("b2b.ld1_valid", 32'(bus.resp_valid), 32'd1);
      check("b2b.ld1_rdata", bus.resp_rdata, 32'h01020304);
      check("b2b.ld1_ready", 32'(bus.req_ready), 32'd0);
      bus.req_we    = 1'b1;
      bus.req_size  = SZ_HALF;
      bus.req_addr  = 16'h0042;
      bus.req_wdata = 32'h0000BEEF;
      step();
      check("b2b.idle_ready", 32'(bus.req_ready), 32'd1);
      check("b2b.idle_resp",  32'(bus.resp_valid), 32'd0);
      step();
      check("b2b.st_wen",   32'(mem_wEn), 32'd1);
      check("b2b.st_wdata", mem_write_data, 32'hBEEF0304);
      check("b2b.st_ready", 32'(bus.req_ready), 32'd0);
      bus.req_we   = 1'b0;
      bus.req_size = SZ_WORD;
      bus.req_addr = 16'h0040;
      step();
      check("b2b.st_valid", 32'(bus.resp_valid), 32'd1);
      check("b2b.st_error", 32'(bus.resp_error), 32'd0);
      check("b2b.st_ready2", 32'(bus.req_ready), 32'd0);
      step();
      check("b2b.idle2_ready", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid = 1'b0;
      check("b2b.ld2_valid", 32'(bus.resp_valid), 32'd1);
      check("b2b.ld2_rdata", bus.resp_rdata, 32'hBEEF0304);
      step();
      check("b2b.end_resp", 32'(bus.resp_valid), 32'd0);
      check("b2b.ram", ram[16'h0040 >> 2], 32'hBEEF0304);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
